// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a kill/keep payload split, a restartable multi-cycle flush window and flush-busy status.
// Define PIPE_STAGE_REG_PERF_EN to add the stall/flush performance counters (stall_cnt_o, flush_cnt_o).
module pipe_stage_reg #(
  parameter int unsigned       KEEP_W       = 32,
  parameter int unsigned       KILL_W       = 44,
  parameter int unsigned       FLUSH_CYCLES = 2,
  parameter logic [KILL_W-1:0] BUBBLE       = '0
) (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [KEEP_W-1:0] keep_i,
  input  logic [KILL_W-1:0] kill_i,
  output logic              valid_o,
  output logic [KEEP_W-1:0] keep_o,
  output logic [KILL_W-1:0] kill_o,
  output logic              flush_busy_o
`ifdef PIPE_STAGE_REG_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(FLUSH_CYCLES - 1);

  generate
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
      $error("pipe_stage_reg: FLUSH_CYCLES=%0d outside legal range 1..15", FLUSH_CYCLES);
    end
  endgenerate

  logic              valid_q, valid_d;
  logic [KEEP_W-1:0] keep_q, keep_d;
  logic [KILL_W-1:0] kill_q, kill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flush_act;
  logic              stall_act;

  // A flush request or a window still counting down takes priority over stall.
  assign flush_act = flush_i || (cnt_q != '0);
  assign stall_act = !flush_act && stall_i;

  always_comb begin
    valid_d = valid_q;
    keep_d  = keep_q;
    kill_d  = kill_q;
    cnt_d   = cnt_q;
    if (flush_act) begin
      keep_d  = keep_i;
      kill_d  = BUBBLE;
      valid_d = 1'b0;
      cnt_d   = flush_i ? RELOAD : (cnt_q - CNT_W'(1));
    end else if (!stall_i) begin
      keep_d  = keep_i;
      kill_d  = kill_i;
      valid_d = valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      valid_q <= 1'b0;
      keep_q  <= '0;
      kill_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      keep_q  <= keep_d;
      kill_q  <= kill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_o      = valid_q;
  assign keep_o       = keep_q;
  assign kill_o       = kill_q;
  assign flush_busy_o = (cnt_q != '0);

`ifdef PIPE_STAGE_REG_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Counters wrap naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_act) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush_act) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  logic unused_stall_act;
  assign unused_stall_act = stall_act;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: two instances (FLUSH_CYCLES=2 default bubble, FLUSH_CYCLES=3 custom bubble) share stimulus.
module tb_pipe_stage_reg;

  localparam logic [43:0] BUB2 = 44'h0;
  localparam logic [43:0] BUB3 = 44'hA5A_5A5A_0F0F;

  logic        clk_i = 1'b0;
  logic        start_i, stall_i, flush_i, valid_i;
  logic [31:0] keep_i;
  logic [43:0] kill_i;

  logic        valid2, busy2, valid3, busy3;
  logic [31:0] keep2, keep3;
  logic [43:0] kill2, kill3;
`ifdef PIPE_STAGE_REG_PERF_EN
  logic [31:0] scnt2, fcnt2, scnt3, fcnt3;
`endif

  always #5 clk_i = ~clk_i;

  pipe_stage_reg #(.KEEP_W(32), .KILL_W(44), .FLUSH_CYCLES(2), .BUBBLE(BUB2)) dut2 (
    .clk_i(clk_i), .start_i(start_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .keep_i(keep_i), .kill_i(kill_i),
    .valid_o(valid2), .keep_o(keep2), .kill_o(kill2), .flush_busy_o(busy2)
`ifdef PIPE_STAGE_REG_PERF_EN
    , .stall_cnt_o(scnt2), .flush_cnt_o(fcnt2)
`endif
  );

  pipe_stage_reg #(.KEEP_W(32), .KILL_W(44), .FLUSH_CYCLES(3), .BUBBLE(BUB3)) dut3 (
    .clk_i(clk_i), .start_i(start_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .keep_i(keep_i), .kill_i(kill_i),
    .valid_o(valid3), .keep_o(keep3), .kill_o(kill3), .flush_busy_o(busy3)
`ifdef PIPE_STAGE_REG_PERF_EN
    , .stall_cnt_o(scnt3), .flush_cnt_o(fcnt3)
`endif
  );

  typedef struct packed {
    logic [31:0] keep;
    logic [43:0] kill;
    logic        valid;
    logic [3:0]  cnt;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } st_t;

  st_t m2, m3;
  st_t q2[$];
  st_t q3[$];
  int  errors = 0;
  int  checks = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference behaviour: reset > flush (request or open window) > stall > normal capture.
  function automatic st_t nxt(input st_t s, input int fc, input logic [43:0] bub);
    st_t n = s;
    if (!start_i) begin
      n = '0;
    end else if (flush_i || s.cnt != 4'd0) begin
      n.keep  = keep_i;
      n.kill  = bub;
      n.valid = 1'b0;
      n.cnt   = flush_i ? 4'(fc - 1) : s.cnt - 4'd1;
      n.fcnt  = s.fcnt + 32'd1;
    end else if (stall_i) begin
      n.scnt  = s.scnt + 32'd1;
    end else begin
      n.keep  = keep_i;
      n.kill  = kill_i;
      n.valid = valid_i;
    end
    return n;
  endfunction

  task automatic step();
    st_t e;
    m2 = nxt(m2, 2, BUB2);
    m3 = nxt(m3, 3, BUB3);
    q2.push_back(m2);
    q3.push_back(m3);
    @(posedge clk_i);
    #1;
    e = q2.pop_front();
    check("fc2.keep", 64'(keep2), 64'(e.keep));
    check("fc2.kill", 64'(kill2), 64'(e.kill));
    check("fc2.valid", 64'(valid2), 64'(e.valid));
    check("fc2.busy", 64'(busy2), 64'(e.cnt != 4'd0));
`ifdef PIPE_STAGE_REG_PERF_EN
    check("fc2.stall_cnt", 64'(scnt2), 64'(e.scnt));
    check("fc2.flush_cnt", 64'(fcnt2), 64'(e.fcnt));
`endif
    e = q3.pop_front();
    check("fc3.keep", 64'(keep3), 64'(e.keep));
    check("fc3.kill", 64'(kill3), 64'(e.kill));
    check("fc3.valid", 64'(valid3), 64'(e.valid));
    check("fc3.busy", 64'(busy3), 64'(e.cnt != 4'd0));
`ifdef PIPE_STAGE_REG_PERF_EN
    check("fc3.stall_cnt", 64'(scnt3), 64'(e.scnt));
    check("fc3.flush_cnt", 64'(fcnt3), 64'(e.fcnt));
`endif
  endtask

  task automatic drive(input logic st, input logic sl, input logic fl, input logic vl,
                       input logic [31:0] kp, input logic [43:0] kl);
    start_i = st; stall_i = sl; flush_i = fl; valid_i = vl; keep_i = kp; kill_i = kl;
  endtask

  initial begin
    m2 = '0;
    m3 = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h1234, 44'hABC);
    @(posedge clk_i);
    #1;

    // Reset held two cycles with live inputs
    step();
    step();
    check("rst.keep", 64'(keep2), 64'h0);
    check("rst.busy", 64'(busy2), 64'h0);

    // Release: one-cycle capture
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h1234, 44'hABC);
    step();
    check("release.keep", 64'(keep2), 64'h1234);
    check("release.kill", 64'(kill2), 64'hABC);

    // Single flush pulse
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 44'h111);
    step();
    check("flush.e1.keep", 64'(keep2), 64'h100);
    check("flush.e1.busy", 64'(busy2), 64'h1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h104, 44'h222);
    step();
    check("flush.e2.keep", 64'(keep2), 64'h104);
    check("flush.e2.kill", 64'(kill2), 64'h0);
    check("flush.e2.busy", 64'(busy2), 64'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h108, 44'h333);
    step();
    check("flush.e3.kill", 64'(kill2), 64'h333);
    check("flush.e3.valid", 64'(valid2), 64'h1);
    step();

    // Restart: back-to-back flush requests
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h110, 44'h444);
    step();
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h114, 44'h555);
    for (int i = 0; i < 3; i++) step();
    check("restart.fc3.busy", 64'(busy3), 64'h0);
    step();

    // Stall hold with changing inputs
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 44'h666);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, i[0], 32'h204 + 32'(i), 44'h777 + 44'(i));
      step();
    end
    check("stall.keep", 64'(keep2), 64'h200);
    check("stall.kill", 64'(kill3), 64'h666);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h210, 44'h888);
    step();
    check("unstall.keep", 64'(keep2), 64'h210);

    // Flush over stall
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 44'h999);
    step();
    check("fos.keep", 64'(keep2), 64'h300);
    check("fos.kill3", 64'(kill3), 64'(BUB3));
    check("fos.valid", 64'(valid2), 64'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h304, 44'hAAA);
    for (int i = 0; i < 3; i++) step();

    // Reset mid-flush, then perf scenario
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 44'hBBB);
    step();
    check("midflush.busy3", 64'(busy3), 64'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h404, 44'hCCC);
    step();
    check("midflush.rst.busy3", 64'(busy3), 64'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h408, 44'hDDD);
    step();
    check("midflush.resume.kill3", 64'(kill3), 64'hDDD);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h40C, 44'hEEE);
    for (int i = 0; i < 5; i++) step();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h410, 44'hFFF);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h414, 44'h123);
    step();
    step();
`ifdef PIPE_STAGE_REG_PERF_EN
    check("perf.stall_cnt", 64'(scnt2), 64'd5);
    check("perf.flush_cnt", 64'(fcnt2), 64'd2);
`endif

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 19) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            1'($urandom), $urandom, {12'($urandom), $urandom});
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register, the successor to the fixed-width fetch/decode latch.
- Carries two payload fields:
  - keep: always advances, even during a flush (e.g. PC).
  - kill: replaced by a bubble during a flush (e.g. instruction, immediates).
- Adds a valid bit, a programmable multi-cycle flush window with restart, and a flush-busy status.
- Instantiated between any two adjacent stages (IF/ID, ID/EX, CGRA issue).

Parameters:
- KEEP_W, 32, width of the keep field.
- KILL_W, 44, width of the kill field.
- FLUSH_CYCLES, 2, number of consecutive bubble cycles per flush request; legal range 1..15.
- BUBBLE, 0 (KILL_W bits), value loaded into kill_o during a flush.

Ports:
- clk_i  in  1  clock, rising edge.
- start_i  in  1  synchronous, active-low reset.
- stall_i  in  1  hold all outputs.
- flush_i  in  1  flush request.
- valid_i  in  1  upstream payload valid.
- keep_i  in  KEEP_W  keep payload in.
- kill_i  in  KILL_W  kill payload in.
- valid_o  out  1  registered valid.
- keep_o  out  KEEP_W  registered keep payload.
- kill_o  out  KILL_W  registered kill payload.
- flush_busy_o  out  1  high while a flush window is still running (cnt != 0).

Behaviour:
- Internal state: flush counter cnt, width clog2(FLUSH_CYCLES+1).
- All updates on rising clk_i, evaluated in the priority order below.
- Reset (start_i=0): keep_o=0, kill_o=0, valid_o=0, cnt=0, flush_busy_o=0.
  - Reset overrides flush and stall; a reset mid-flush aborts the window immediately.
- Flush (flush_i=1 or cnt!=0):
  - Outputs: keep_o<=keep_i, kill_o<=BUBBLE, valid_o<=0.
  - If flush_i=1: cnt<=FLUSH_CYCLES-1. A new flush during an active window restarts the window rather than extending it by a partial amount.
  - Else: cnt<=cnt-1.
  - Result: exactly FLUSH_CYCLES bubble cycles counted from the last flush_i edge.
  - FLUSH_CYCLES=1 gives a single-cycle flush with cnt always 0.
- Flush has priority over stall: keep_o still advances during a flush even if stall_i=1.
- Stall (stall_i=1, no flush active): all outputs and cnt hold.
- Normal: keep_o<=keep_i, kill_o<=kill_i, valid_o<=valid_i, cnt stays 0.
- Latency: 1 cycle, input to output, in the normal case.
- flush_busy_o is registered (it is the cnt!=0 decode). In the cycle after the last bubble is captured it is 0 and normal capture resumes.
- Elaboration check: FLUSH_CYCLES outside 1..15 fails elaboration via $error inside a generate.
- No combinational path from any input to any output.

Optional Feature:
- Macro: PIPE_STAGE_REG_PERF_EN.
- When defined, adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0]:
  - stall_cnt_o increments each cycle the stall branch is taken.
  - flush_cnt_o increments each bubble cycle.
  - Both are cleared by reset and wrap from 0xFFFFFFFF to 0.
- When not defined: the ports and counters are absent; no other behaviour changes.

Test Plan:
- Reset: start_i=0 for 2 cycles with keep_i=0x1234, kill_i=0xABC -> all outputs 0, flush_busy_o=0. Release start_i -> next edge keep_o=0x1234, kill_o=0xABC, valid_o=valid_i.
- Two-cycle flush (FLUSH_CYCLES=2): flush_i pulsed 1 cycle while keep_i=0x100,0x104 on successive cycles -> kill_o=0 and valid_o=0 for 2 edges; keep_o=0x100 then 0x104; flush_busy_o=1 for 1 cycle; third edge loads kill_i.
- Restart: flush_i at cycle 0 and again at cycle 1 (FLUSH_CYCLES=3) -> bubbles at edges 0..3 (4 total), flush_busy_o low only after edge 3.
- Stall hold: stall_i=1 for 3 cycles with changing inputs -> outputs frozen at the pre-stall value (e.g. keep_o=0x200); drop stall -> capture resumes with 1-cycle latency.
- Flush over stall: stall_i=1 and flush_i=1 together, keep_i=0x300 -> keep_o=0x300, kill_o=BUBBLE, valid_o=0.
- Reset mid-flush plus perf: assert start_i=0 while flush_busy_o=1 -> cnt=0 and flush_busy_o=0 next edge. With PIPE_STAGE_REG_PERF_EN: 5 stall cycles and 1 flush (FLUSH_CYCLES=2) -> stall_cnt_o=5, flush_cnt_o=2.
